// File: rtl/pulse_meter_if.sv
// pulse_meter bus: sampled amplitude in, pulse measurement results out.
// master drives sig and observes results; slave is the meter.
interface pulse_meter_if #(
  parameter int W_CNT = 16
);
  logic [2:0]       sig;
  logic [W_CNT-1:0] width;
  logic [W_CNT-1:0] period;
  logic [2:0]       level;
  logic             level_err;
  logic             meas_valid;
  logic             timeout;

  modport master (
    output sig,
    input  width, period, level,
    input  level_err, meas_valid, timeout
  );

  modport slave (
    input  sig,
    output width, period, level,
    output level_err, meas_valid, timeout
  );
endinterface

// File: rtl/pulse_meter.sv
// pulse_meter: measures width/period/level of a 3-bit pulse stream.
// Optional PULSE_METER_SYNC_EN adds a 2-flop input synchronizer.
module pulse_meter #(
  parameter int W_CNT   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  pulse_meter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [W_CNT-1:0] C_TMO = W_CNT'(TIMEOUT);
  localparam logic [W_CNT-1:0] C_MAX = '1;
  localparam logic [W_CNT-1:0] C_ONE = W_CNT'(1);

  state_t           r_state;
  logic [2:0]       r_prev;
  logic [W_CNT-1:0] r_w;
  logic [W_CNT-1:0] r_p;
  logic [W_CNT-1:0] r_idle;
  logic [2:0]       r_lvl0;
  logic             r_err;
  logic [W_CNT-1:0] r_width;
  logic [W_CNT-1:0] r_period;
  logic [2:0]       r_level;
  logic             r_level_err;
  logic             r_valid;
  logic             r_timeout;

  logic [2:0]       w_sig;
  logic             w_rise;
  logic             w_fall;
  logic [W_CNT-1:0] w_p_nxt;
  logic [W_CNT-1:0] w_w_nxt;
  logic [W_CNT-1:0] w_i_nxt;
  logic             w_tmo;

`ifdef PULSE_METER_SYNC_EN
  logic [2:0] r_s1;
  logic [2:0] r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= bus.sig;
      r_s2 <= r_s1;
    end
  end

  assign w_sig = r_s2;
`else
  assign w_sig = bus.sig;
`endif

  assign w_rise  = (r_prev == '0) && (w_sig != '0);
  assign w_fall  = (r_prev != '0) && (w_sig == '0);
  assign w_p_nxt = (r_p == C_MAX) ? r_p : r_p + C_ONE;
  assign w_w_nxt = (r_w == C_MAX) ? r_w : r_w + C_ONE;
  assign w_i_nxt = (r_idle == C_MAX) ? r_idle : r_idle + C_ONE;
  assign w_tmo   = (w_p_nxt == C_TMO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_w         <= '0;
      r_p         <= '0;
      r_idle      <= '0;
      r_lvl0      <= '0;
      r_err       <= 1'b0;
      r_width     <= '0;
      r_period    <= '0;
      r_level     <= '0;
      r_level_err <= 1'b0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_prev  <= w_sig;
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state   <= HIGH;
            r_p       <= C_ONE;
            r_w       <= C_ONE;
            r_lvl0    <= w_sig;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_idle    <= '0;
          end else if (!r_timeout) begin
            r_idle <= w_i_nxt;
            if (w_i_nxt == C_TMO) r_timeout <= 1'b1;
          end
        end
        HIGH: begin
          if (w_tmo) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
            r_idle    <= '0;
          end else begin
            r_p <= w_p_nxt;
            if (w_sig != '0) begin
              r_w <= w_w_nxt;
              if (w_sig != r_lvl0) r_err <= 1'b1;
            end
            if (w_fall) r_state <= LOW;
          end
        end
        LOW: begin
          if (w_rise) begin
            // publish and restart on the same edge
            r_period    <= r_p;
            r_width     <= r_w;
            r_level     <= r_lvl0;
            r_level_err <= r_err;
            r_valid     <= 1'b1;
            r_state     <= HIGH;
            r_p         <= C_ONE;
            r_w         <= C_ONE;
            r_lvl0      <= w_sig;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
          end else if (w_tmo) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
            r_idle    <= '0;
          end else begin
            r_p <= w_p_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.width      = r_width;
  assign bus.period     = r_period;
  assign bus.level      = r_level;
  assign bus.level_err  = r_level_err;
  assign bus.meas_valid = r_valid;
  assign bus.timeout    = r_timeout;
endmodule

// File: doc/pulse_meter.md
# pulse_meter

Downstream measurement stage for the rectangular pulse generator's 3-bit `out` waveform. It samples the amplitude stream every clock, detects pulse edges, and reports each completed pulse's width, period and amplitude with a one-cycle valid strobe. It also flags amplitude changes inside a pulse and loss of pulses (timeout). Results drive the board display and self-check logic.

## Interface
Parameters:
- `W_CNT`, 16: width of the width/period counters and result buses.
- `TIMEOUT`, 1000: cycles without a rising edge before `timeout` asserts. Constraint: 2 ≤ `TIMEOUT` ≤ 2^`W_CNT` − 2.

Ports:
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sig`, in, 3: sampled amplitude. 0 means low; any nonzero value means high.
- `width`, out, `W_CNT`: number of nonzero samples in the last measured period.
- `period`, out, `W_CNT`: number of samples between the last two rising edges.
- `level`, out, 3: value of `sig` on the first sample of the last measured pulse.
- `level_err`, out, 1: the last measured pulse held more than one nonzero value.
- `meas_valid`, out, 1: one-cycle strobe; the four result outputs above were updated this cycle.
- `timeout`, out, 1: level signal; no rising edge has been seen for `TIMEOUT` cycles.

## Operation
- Registered previous sample `s_prev`; reset value 0.
- Rise: `s_prev` == 0 and `sig` != 0. Fall: `s_prev` != 0 and `sig` == 0. A change from one nonzero value to another is neither a rise nor a fall.
- Internal counters: `w_cnt`, `p_cnt` (both `W_CNT` bits), `lvl0` (3 bits), `err` (1 bit).
- FSM states:
  - IDLE: wait for a rise.
    - On a rise: go to HIGH; `p_cnt` = 1, `w_cnt` = 1, `lvl0` = `sig`, `err` = 0, `timeout` cleared.
    - No `meas_valid` is issued.
  - HIGH: each cycle `p_cnt`++.
    - If `sig` != 0: `w_cnt`++; `err` is set if `sig` != `lvl0`.
    - On a fall: go to LOW.
  - LOW: each cycle `p_cnt`++.
    - On a rise: publish the result, then restart the counters exactly as on IDLE→HIGH and go to HIGH.
    - Publishing means `period` = `p_cnt`, `width` = `w_cnt`, `level` = `lvl0`, `level_err` = `err`, and `meas_valid` = 1.
- Timeout:
  - In HIGH or LOW, when `p_cnt` reaches `TIMEOUT` with no rise: go to IDLE, set `timeout` = 1, discard the partial measurement, and leave the result outputs unchanged.
  - In IDLE, an idle counter also counts to `TIMEOUT` and then sets `timeout`. This covers a constant-0 input from reset.
  - A constant nonzero input (100 % duty) therefore times out from HIGH.
- Reset:
  - `rst` at any time, including mid-measurement, forces IDLE.
  - All outputs return to 0 and `s_prev`, counters and flags clear.
  - Because `s_prev` resets to 0, a nonzero `sig` on the first sample after reset counts as a rise.
- Counters saturate at 2^`W_CNT` − 1. The `TIMEOUT` constraint guarantees `p_cnt` never saturates in normal operation.

## Timing
- `meas_valid` and the result outputs update at the same clock edge that samples the rise, so latency is 1 cycle from `sig` to outputs.
- `meas_valid` is high for exactly 1 cycle per completed period. The minimum spacing between strobes is 2 cycles (period 2, width 1).
- `timeout` asserts at the clock edge where the count reaches `TIMEOUT`. It deasserts at the clock edge that samples the next rise.
- Results hold their value between strobes.

## Configuration
- `PULSE_METER_SYNC_EN` defined:
  - `sig` passes through a two-flop synchronizer (reset value 0) before edge detection.
  - All latencies increase by 2 cycles.
  - Use this for asynchronous or off-board inputs.
- Not defined: `sig` is used directly. It must already be synchronous to `clk`.

## Test plan
- Periodic 3,3,0,0 input, repeated → from the second rise on, `meas_valid` every 4 cycles with `period` = 4, `width` = 2, `level` = 3, `level_err` = 0.
- Pattern 2,5,0,0 → `level` = 2, `level_err` = 1, `width` = 2, `period` = 4.
- `sig` held at 4 for `TIMEOUT` cycles after a rise → `timeout` = 1, no `meas_valid`, results unchanged. Then 0 followed by 1 → `timeout` clears on the rise with no strobe; the next full period strobes normally.
- `sig` = 0 from reset → `timeout` asserts after `TIMEOUT` cycles and all result outputs stay 0.
- `rst` asserted mid-HIGH → all outputs 0 on the next cycle. A 1,0,0 pattern afterwards gives its first strobe at the second rise with `period` = 3, `width` = 1.
- With `PULSE_METER_SYNC_EN` defined, repeat the first scenario → same values, strobes delayed by 2 cycles.
